// File: rtl/led_matrix_capture.sv
// rtl/led_matrix_capture.sv - rebuilds an 8x8 bicolour frame from a multiplexed LED scan bus
module led_matrix_capture #(
    parameter int MIN_DWELL = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       nst,
    input  logic [7:0] led_row,
    input  logic [7:0] led_r_col,
    input  logic [7:0] led_g_col,
    input  logic [2:0] rd_row,
    output logic [7:0] rd_r,
    output logic [7:0] rd_g,
    output logic       frame_done,
    output logic       row_err,
    output logic       scan_lost
);

    localparam logic [7:0]  DWELL = 8'(MIN_DWELL);
    localparam logic [15:0] TO    = 16'(TIMEOUT);

    logic [23:0] tuple_in;
    logic [23:0] s_tuple_q;
    logic [7:0]  run_q, run_d;
    logic [15:0] to_q, to_d;
    logic [7:0]  seen_q, seen_d;
    logic [7:0]  seen_set;
    logic [3:0]  zero_cnt;
    logic [2:0]  row_idx;
    logic        accept, valid, multi, frame_full, timed_out;
    logic        frame_done_q, row_err_q, scan_lost_q;
    logic [7:0]  rd_r_q, rd_g_q;
    logic [7:0]  work_r_q [8];
    logic [7:0]  work_g_q [8];
    logic [7:0]  disp_r_q [8];
    logic [7:0]  disp_g_q [8];

    assign tuple_in = {led_row, led_r_col, led_g_col};

    // Dwell tracking, row classification and timeout/seen next-state.
    always_comb begin
        run_d = 8'd1;
        if (tuple_in == s_tuple_q) begin
            run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
        end
        // run_d restarts at 1 on any change, so hitting DWELL means the bus is stable
        accept   = (run_d == DWELL);
        zero_cnt = 4'd0;
        row_idx  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!led_row[i]) begin
                zero_cnt = zero_cnt + 4'd1;
                row_idx  = 3'(i);
            end
        end
        valid      = accept && (zero_cnt == 4'd1);
        multi      = accept && (zero_cnt >= 4'd2);
        seen_set   = seen_q | (8'd1 << row_idx);
        frame_full = valid && (seen_set == 8'hFF);
        to_d       = 16'd0;
        if (!valid) begin
            to_d = (to_q == 16'hFFFF) ? to_q : to_q + 16'd1;
        end
        timed_out = !valid && (to_d == TO);
        seen_d    = seen_q;
        if (frame_full) begin
            seen_d = 8'h00;
        end else if (valid) begin
            seen_d = seen_set;
        end else if (timed_out) begin
            seen_d = 8'h00;
        end
    end

    // Control state: sampler, counters, seen mask and status pulses.
    always_ff @(posedge clk) begin
        if (!nst) begin
            s_tuple_q    <= 24'd0;
            run_q        <= 8'd0;
            to_q         <= 16'd0;
            seen_q       <= 8'd0;
            frame_done_q <= 1'b0;
            row_err_q    <= 1'b0;
            scan_lost_q  <= 1'b0;
        end else begin
            s_tuple_q    <= tuple_in;
            run_q        <= run_d;
            to_q         <= to_d;
            seen_q       <= seen_d;
            frame_done_q <= frame_full;
            row_err_q    <= multi;
            if (valid) begin
                scan_lost_q <= 1'b0;
            end else if (timed_out) begin
                scan_lost_q <= 1'b1;
            end
        end
    end

    // Working/display buffers and the registered read port.
    always_ff @(posedge clk) begin
        if (!nst) begin
            for (int j = 0; j < 8; j++) begin
                work_r_q[j] <= 8'd0;
                work_g_q[j] <= 8'd0;
                disp_r_q[j] <= 8'd0;
                disp_g_q[j] <= 8'd0;
            end
            rd_r_q <= 8'd0;
            rd_g_q <= 8'd0;
        end else begin
            // read samples the display before any copy on this edge lands
            rd_r_q <= disp_r_q[rd_row];
            rd_g_q <= disp_g_q[rd_row];
            if (valid) begin
                work_r_q[row_idx] <= led_r_col;
                work_g_q[row_idx] <= led_g_col;
            end
            if (frame_full) begin
                // the row completing the frame bypasses the working buffer
                for (int j = 0; j < 8; j++) begin
                    disp_r_q[j] <= (3'(j) == row_idx) ? led_r_col : work_r_q[j];
                    disp_g_q[j] <= (3'(j) == row_idx) ? led_g_col : work_g_q[j];
                end
            end
        end
    end

    assign rd_r       = rd_r_q;
    assign rd_g       = rd_g_q;
    assign frame_done = frame_done_q;
    assign row_err    = row_err_q;
    assign scan_lost  = scan_lost_q;

endmodule

// File: tb/tb_led_matrix_capture.sv
// tb/tb_led_matrix_capture.sv - directed self-checking bench for led_matrix_capture
module tb_led_matrix_capture;

    localparam int DW = 4;
    localparam int TO = 256;

    logic       clk = 1'b0;
    logic       nst = 1'b0;
    logic [7:0] led_row = 8'hFF;
    logic [7:0] led_r_col = 8'h00;
    logic [7:0] led_g_col = 8'h00;
    logic [2:0] rd_row = 3'd0;
    logic [7:0] rd_r, rd_g;
    logic       frame_done, row_err, scan_lost;

    int n_assert = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;
    int re_cnt   = 0;
    int fd0, re0;
    logic [7:0] oh;

    led_matrix_capture #(.MIN_DWELL(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .nst(nst), .led_row(led_row), .led_r_col(led_r_col),
        .led_g_col(led_g_col), .rd_row(rd_row), .rd_r(rd_r), .rd_g(rd_g),
        .frame_done(frame_done), .row_err(row_err), .scan_lost(scan_lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (row_err === 1'b1) re_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] row, input logic [7:0] r, input logic [7:0] g, input int n);
        led_row   = row;
        led_r_col = r;
        led_g_col = g;
        repeat (n) tick();
    endtask

    task automatic rd(input string tag, input logic [2:0] idx, input logic [7:0] er, input logic [7:0] eg);
        rd_row = idx;
        tick();
        chk(tag, {rd_r, rd_g}, {er, eg});
    endtask

    initial begin
        // reset with random bus activity
        nst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            led_row   = 8'($urandom);
            led_r_col = 8'($urandom);
            led_g_col = 8'($urandom);
            tick();
        end
        chk("rst_rd_r", 16'(rd_r), 16'h00);
        chk("rst_rd_g", 16'(rd_g), 16'h00);
        chk("rst_frame_done", 16'(frame_done), 16'h0);
        chk("rst_row_err", 16'(row_err), 16'h0);
        chk("rst_scan_lost", 16'(scan_lost), 16'h0);
        nst = 1'b1;
        drive(8'hFF, 8'h00, 8'h00, 1);
        for (int i = 0; i < 8; i++) rd("rst_read", 3'(i), 8'h00, 8'h00);

        // full frame, checking exact frame_done timing on row 7
        for (int i = 0; i < 7; i++) begin
            oh = 8'h01 << i;
            drive(~oh, oh, ~oh, 6);
        end
        drive(8'h7F, 8'h80, 8'h7F, 3);
        chk("fd_before", 16'(frame_done), 16'h0);
        tick();
        chk("fd_pulse", 16'(frame_done), 16'h1);
        tick();
        chk("fd_after", 16'(frame_done), 16'h0);
        drive(8'h7F, 8'h80, 8'h7F, 1);
        drive(8'hFF, 8'h00, 8'h00, 1);
        chk("fd_count_frame1", 16'(fd_cnt), 16'd1);
        rd("f1_row3", 3'd3, 8'h08, 8'hF7);
        rd("f1_row7", 3'd7, 8'h80, 8'h7F);

        // glitch: 3-cycle row 2 pattern between rows 5 and 6
        fd0 = fd_cnt;
        for (int i = 0; i < 8; i++) begin
            oh = 8'h01 << i;
            drive(~oh, oh, ~oh, 6);
            if (i == 5) drive(8'hFB, 8'hFF, 8'h00, DW - 1);
        end
        drive(8'hFF, 8'h00, 8'h00, 1);
        chk("glitch_fd_count", 16'(fd_cnt - fd0), 16'd1);
        rd("glitch_row2", 3'd2, 8'h04, 8'hFB);

        // illegal row pattern mid-frame
        fd0 = fd_cnt;
        re0 = re_cnt;
        for (int i = 0; i < 4; i++) drive(~(8'h01 << i), 8'h30 + 8'(i), 8'hA0 + 8'(i), 6);
        drive(8'hF3, 8'hFF, 8'hFF, 3);
        chk("re_before", 16'(row_err), 16'h0);
        tick();
        chk("re_pulse", 16'(row_err), 16'h1);
        tick();
        chk("re_after", 16'(row_err), 16'h0);
        chk("re_no_fd", 16'(fd_cnt - fd0), 16'd0);
        for (int i = 4; i < 8; i++) drive(~(8'h01 << i), 8'h30 + 8'(i), 8'hA0 + 8'(i), 6);
        drive(8'hFF, 8'h00, 8'h00, 1);
        chk("re_count", 16'(re_cnt - re0), 16'd1);
        chk("re_fd_count", 16'(fd_cnt - fd0), 16'd1);
        rd("ill_row2", 3'd2, 8'h32, 8'hA2);
        rd("ill_row3", 3'd3, 8'h33, 8'hA3);

        // overwrite of row 0 before the frame completes
        fd0 = fd_cnt;
        for (int i = 0; i < 6; i++) begin
            oh = 8'h01 << i;
            drive(~oh, oh, ~oh, 6);
        end
        drive(8'hFE, 8'hAA, 8'h55, 6);
        chk("ow_no_fd", 16'(fd_cnt - fd0), 16'd0);
        drive(8'hBF, 8'h40, 8'hBF, 6);
        drive(8'h7F, 8'h80, 8'h7F, 6);
        drive(8'hFF, 8'h00, 8'h00, 1);
        chk("ow_fd_count", 16'(fd_cnt - fd0), 16'd1);
        rd("ow_row0", 3'd0, 8'hAA, 8'h55);
        rd("ow_row1", 3'd1, 8'h02, 8'hFD);

        // timeout after a partial frame
        for (int i = 0; i < 3; i++) drive(~(8'h01 << i), 8'h11, 8'h22, 6);
        drive(8'hF7, 8'h77, 8'h88, DW);
        drive(8'hFF, 8'h00, 8'h00, TO - 1);
        chk("sl_before", 16'(scan_lost), 16'h0);
        tick();
        chk("sl_set", 16'(scan_lost), 16'h1);
        rd("sl_disp_kept", 3'd0, 8'hAA, 8'h55);
        fd0 = fd_cnt;
        drive(8'hEF, 8'hE4, 8'h04, DW - 1);
        chk("sl_hold", 16'(scan_lost), 16'h1);
        tick();
        chk("sl_clear", 16'(scan_lost), 16'h0);
        drive(8'hEF, 8'hE4, 8'h04, 2);
        for (int i = 5; i < 8; i++) drive(~(8'h01 << i), 8'hE0 + 8'(i), 8'(i), 6);
        chk("sl_no_early_fd", 16'(fd_cnt - fd0), 16'd0);
        for (int i = 0; i < 4; i++) drive(~(8'h01 << i), 8'hE0 + 8'(i), 8'(i), 6);
        drive(8'hFF, 8'h00, 8'h00, 1);
        chk("sl_fd_count", 16'(fd_cnt - fd0), 16'd1);
        rd("sl_row3", 3'd3, 8'hE3, 8'h03);

        // reset mid-frame discards everything and raises no frame_done
        for (int i = 0; i < 3; i++) drive(~(8'h01 << i), 8'h5A, 8'hA5, 6);
        fd0 = fd_cnt;
        nst = 1'b0;
        drive(8'hFF, 8'h00, 8'h00, 2);
        chk("mid_rst_fd", 16'(frame_done), 16'h0);
        nst = 1'b1;
        rd("mid_rst_row0", 3'd0, 8'h00, 8'h00);
        drive(8'hFF, 8'h00, 8'h00, 2);
        chk("mid_rst_fd_count", 16'(fd_cnt - fd0), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
